sipo_deserializer: RTL
======================

Name: sipo_deserializer

Overview:
- Serial-in, parallel-out receiver: the far end of the team's parallel-load shift-register path. A PISO-style transmitter shifts words out MSB-first; this block collects them.
- Shifts in one bit per qualified clock and assembles WIDTH-bit words. Each completed word goes to a double-buffered output register with a valid/ready handshake toward the consumer.
- Sits between a serial link and a parallel datapath (register file, FIFO, PIPO stage).

Parameters:
- WIDTH, 4, data word width in bits (>= 2).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; same role as the codebase reset, low asserts.
- serial_in  input  1  serial data bit, sampled only when serial_valid=1.
- serial_valid  input  1  qualifies serial_in this cycle.
- sync_clr  input  1  synchronous frame realign: discards the partial word and sets bit counter to 0.
- out_ready  input  1  consumer accepts parallel_out this cycle.
- ovr_clr  input  1  synchronous clear of the overrun flag.
- parallel_out  output  WIDTH  last completed word; MSB is the first bit received.
- out_valid  output  1  parallel_out holds an unconsumed word.
- busy  output  1  partial word in progress (bit count != 0).
- overrun  output  1  sticky: a word completed while the output buffer was full and not being drained.

Behaviour:
- Reset (rst_n=0, asynchronous): shift register=0, bit count=0, parallel_out=0, out_valid=0, overrun=0, busy=0. Any partial word is lost. Operation resumes on the first edge after rst_n=1.
- Bit counter: width clog2(WIDTH) (clog2(WIDTH+1) with parity). Range 0..FRAME-1, where FRAME=WIDTH (WIDTH+1 with parity). Wraps to 0 when a frame completes.
- Shift: on an edge with serial_valid=1 and sync_clr=0: sh <= {sh[WIDTH-2:0], serial_in}; count increments.
- sync_clr=1 has priority over serial_valid: count <= 0, sh <= 0, and the bit presented that cycle is dropped. Output buffer and flags are unaffected.
- Completion edge: serial_valid=1 and count==FRAME-1. Completed word C = {sh[WIDTH-2:0], serial_in}. This is a single-cycle latency: parallel_out/out_valid are visible immediately after the edge that samples the last bit.
- Output buffer, two states, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY + completion: parallel_out <= C, go FULL.
  - FULL + out_ready=1, no completion: go EMPTY. parallel_out keeps its old value.
  - FULL + out_ready=1 + completion on the same edge: parallel_out <= C, stay FULL. No overrun.
  - FULL + out_ready=0 + completion: C is dropped, the held word is preserved, overrun <= 1.
  - out_ready while EMPTY is ignored.
- Shifting never stalls: the input side is independent of output backpressure.
- overrun: cleared by ovr_clr=1. If a set and a clear land on the same edge, set wins.
- busy = (count != 0), registered-equivalent (derived from the count register).
- serial_valid gaps of any length are allowed mid-word; the count holds during the gap.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - FRAME = WIDTH+1. The final bit is an even-parity bit over the WIDTH data bits.
  - Extra output port parity_err (1 bit, reset 0). It updates on every completion edge that loads parallel_out: 1 if the XOR of the data bits and the parity bit is 1, else 0.
  - On a dropped (overrun) word, parity_err is unchanged.
  - The parity bit is not shifted into parallel_out.
- Undefined: FRAME = WIDTH, and port parity_err does not exist.

Test Plan:
- Basic word (WIDTH=4, out_ready=1): serial_valid=1, bits 1,0,1,1 on 4 consecutive edges -> after the 4th edge parallel_out=4'b1011, out_valid=1 for exactly 1 cycle, busy=0, overrun=0.
- Back-to-back with simultaneous drain: bits 1011 then 1100 continuously, out_ready=1 -> 1011 valid 1 cycle, then 1100 valid after the 8th edge; no overrun.
- Backpressure/overrun: out_ready=0, send 1011 then 0110 -> parallel_out stays 1011, out_valid=1, overrun=1 after the 8th edge; pulse ovr_clr -> overrun=0; out_ready=1 -> out_valid=0 next cycle.
- Gaps and realign: send 1,0; serial_valid=0 for 3 cycles (busy=1, count holds); sync_clr=1 -> busy=0; then send 0,1,1,1 -> parallel_out=0111.
- Async reset mid-word: send 1,1; drop rst_n between clock edges -> all outputs 0 immediately; release; send 0,0,0,1 -> parallel_out=0001.
- Parity (SIPO_PARITY_EN): send 1011 plus parity 1 -> parallel_out=1011, parity_err=0; send 1011 plus parity 0 -> parity_err=1.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: assembles MSB-first words into a double-buffered
// valid/ready output register. Define SIPO_PARITY_EN to append an even-parity bit per frame.
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             sync_clr,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
`ifdef SIPO_PARITY_EN
  output logic             parity_err,
`endif
  output logic             dbg_buf_full
);

  // Handshake: a word transfers on any edge where out_valid=1 and out_ready=1;
  // out_valid stays high with parallel_out stable until that transfer happens.

`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  buf_state_e       state_q, state_d;
  logic             overrun_q, overrun_d;
  logic             pe_q, pe_d;

  logic             shift_en;
  logic             complete;
  logic             load;
  logic             ovr_set;
  logic [WIDTH-1:0] word_c;

  always_comb begin
    shift_en = serial_valid & ~sync_clr;
    complete = shift_en & (cnt_q == CNT_LAST);
    sh_d     = sh_q;
    cnt_d    = cnt_q;

    if (sync_clr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (serial_valid) begin
      cnt_d = complete ? '0 : cnt_q + 1'b1;
`ifdef SIPO_PARITY_EN
      // The parity bit is checked, never shifted into the data word.
      if (!complete) sh_d = {sh_q[WIDTH-2:0], serial_in};
`else
      sh_d = {sh_q[WIDTH-2:0], serial_in};
`endif
    end
  end

`ifdef SIPO_PARITY_EN
  assign word_c = sh_q;
`else
  assign word_c = {sh_q[WIDTH-2:0], serial_in};
`endif

  always_comb begin
    state_d = state_q;
    po_d    = po_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (complete) begin
          // Draining on the same edge frees the slot for the new word.
          if (out_ready) load = 1'b1;
          else           ovr_set = 1'b1;
        end else if (out_ready) begin
          state_d = BUF_EMPTY;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    if (load) po_d = word_c;

    overrun_d = ovr_set | (overrun_q & ~ovr_clr);
    pe_d      = load ? ((^sh_q) ^ serial_in) : pe_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      po_q      <= '0;
      state_q   <= BUF_EMPTY;
      overrun_q <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      po_q      <= po_d;
      state_q   <= state_d;
      overrun_q <= overrun_d;
      pe_q      <= pe_d;
    end
  end

  assign parallel_out = po_q;
  assign out_valid    = (state_q == BUF_FULL);
  assign busy         = (cnt_q != '0);
  assign overrun      = overrun_q;
  assign dbg_buf_full = (state_q == BUF_FULL);
`ifdef SIPO_PARITY_EN
  assign parity_err   = pe_q;
`else
  // Parity tracking only matters when the frame carries a parity bit.
  logic unused_pe;
  assign unused_pe = pe_q;
`endif

endmodule
